// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: receiver FSM encoding, frame geometry and the break code
// that the downstream scan-code FIFO also recognises.
package ps2_defs;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DPS  = 2'b01,
        LOAD = 2'b10
    } rx_state_t;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_BRK        = 8'hF0;

    // Odd parity holds when data plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] data_par);
        return ^data_par;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioning: 2-flop data synchroniser, FILTER_LEN-sample clock debounce
// and a registered one-cycle pulse on each falling edge of the filtered clock.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic ps2d_sync,
    output logic fall_edge
);

    logic [FILTER_LEN-1:0] filter_reg;
    logic                  filt_clk;
    logic [1:0]            d_sync;

    // The filtered level only moves once the whole window agrees; mixed windows hold it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filter_reg <= '1;
            filt_clk   <= 1'b1;
            fall_edge  <= 1'b0;
            d_sync     <= 2'b11;
        end else begin
            filter_reg <= {ps2c, filter_reg[FILTER_LEN-1:1]};
            d_sync     <= {d_sync[0], ps2d};
            fall_edge  <= 1'b0;
            if (&filter_reg) begin
                filt_clk <= 1'b1;
            end else if (~|filter_reg) begin
                filt_clk  <= 1'b0;
                fall_edge <= filt_clk;
            end
        end
    end

    assign ps2d_sync = d_sync[1];

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: deserialises start/8 data/odd parity/stop and
// strobes each good byte into the scan-code FIFO; bad frames raise an error pulse.
module ps2_rx_frame
    import ps2_defs::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int TW             = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [3:0]    BIT_CNT_LOAD = 4'(PS2_FRAME_BITS - 2);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic ps2d_sync;
    logic fall_edge;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2c     (ps2c),
        .ps2d     (ps2d),
        .ps2d_sync(ps2d_sync),
        .fall_edge(fall_edge)
    );

    rx_state_t     state, state_next;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [9:0]    shreg, shreg_next;
    logic [TW-1:0] tcnt, tcnt_next;
    logic [7:0]    dout_next;
    logic          done_next, perr_next, ferr_next;
    logic [9:0]    frame;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            tcnt         <= '0;
            dout         <= 8'h00;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            shreg        <= shreg_next;
            tcnt         <= tcnt_next;
            dout         <= dout_next;
            rx_done_tick <= done_next;
            parity_err   <= perr_next;
            frame_err    <= ferr_next;
        end
    end

    // Frame as it stands once the bit arriving on this edge is shifted in (LSB first).
    assign frame = {ps2d_sync, shreg[9:1]};

    // The frame is judged on the stop-bit edge so that dout and the strobe both land
    // in the LOAD cycle, one clock after that edge's fall_edge pulse.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        tcnt_next    = tcnt;
        dout_next    = dout;
        done_next    = 1'b0;
        perr_next    = 1'b0;
        ferr_next    = 1'b0;
        case (state)
            IDLE: begin
                if (fall_edge && rx_en) begin
                    if (!ps2d_sync) begin
                        bit_cnt_next = BIT_CNT_LOAD;
                        tcnt_next    = '0;
                        state_next   = DPS;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end
            end
            DPS: begin
                if (fall_edge) begin
                    shreg_next = frame;
                    tcnt_next  = '0;
                    if (bit_cnt == 4'd0) begin
                        state_next = LOAD;
                        if (!frame[9]) begin
                            ferr_next = 1'b1;
                        end else if (!odd_parity_ok(frame[8:0])) begin
                            perr_next = 1'b1;
                        end else begin
                            dout_next = frame[7:0];
                            done_next = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt - 4'd1;
                    end
                end else if (tcnt == TIMEOUT_LAST) begin
                    ferr_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt + 1'b1;
                end
            end
            LOAD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
